sdr_width_conv_engine: RTL and testbench

Parametrised application-to-SDRAM data-width converter between the app-side request path and the SDRAM transfer engine. It splits each app write word into 1/2/4/8 SDR lanes and assembles SDR read lanes back into full app words. It generalises the fixed 32-bit/16-bit/8-bit handling to a parametrised app width and adds an eighth-width mode. It adds registered read output plus sticky protocol-error detection for partial bursts and mid-burst mode changes.

---
 rtl/sdr_width_conv_engine.sv | 146 ++++++++++++++
 tb/tb_sdr_width_conv_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_width_conv_engine.sv
// App-to-SDRAM data-width converter: splits app write words into 1/2/4/8 SDR lanes
// and reassembles SDR read lanes into app words, with sticky protocol-error flags.
module sdr_width_conv_engine #(
    parameter int APP_DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        sdr_width,
    input  logic [APP_DW-1:0] app_wr_data,
    output logic              app_wr_next,
    input  logic              x2a_wrstart,
    input  logic              x2a_wrnext,
    input  logic              x2a_wrlast,
    output logic [APP_DW-1:0] a2x_wrdt,
    input  logic              x2a_rdok,
    input  logic              x2a_rdlast,
    input  logic [APP_DW-1:0] x2a_rddt,
    output logic [APP_DW-1:0] app_rd_data,
    output logic              app_rd_valid,
    output logic [2:0]        wr_xfr_count,
    output logic [2:0]        rd_xfr_count,
    output logic              wr_partial_err,
    output logic              rd_partial_err,
    output logic              mode_err,
    input  logic              err_clr
);

    localparam int LANE_MIN = APP_DW / 8;
    localparam logic [APP_DW-1:0] ALL_ONES = '1;

    logic [1:0]        width_q;
    logic [APP_DW-1:0] rd_buf;
    logic [2:0]        last_idx;
    logic [8:0]        lane_w;
    logic [8:0]        wr_shift;
    logic [8:0]        rd_shift;
    logic [APP_DW-1:0] lane_mask;
    logic [APP_DW-1:0] rd_lane;
    logic [APP_DW-1:0] rd_merged;
    logic              mode_chg;
    logic [2:0]        wr_base;
    logic              wr_at_end;
    logic              rd_at_end;
    logic [2:0]        wr_cnt_nxt;
    logic [2:0]        rd_cnt_nxt;
    logic              wr_err_set;
    logic              rd_err_set;
    logic              rd_load;
    logic              rd_done;

    always_comb begin
        case (sdr_width)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            2'b10:   last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    end

    // Lane width is LANE_MIN scaled by 8/4/2/1; inverting the width code gives that exponent.
    assign lane_w    = 9'(LANE_MIN) << (~sdr_width);
    assign lane_mask = ALL_ONES >> (9'(APP_DW) - lane_w);
    assign wr_shift  = 9'(wr_xfr_count) * lane_w;
    assign rd_shift  = 9'(rd_xfr_count) * lane_w;

    assign a2x_wrdt  = (app_wr_data >> wr_shift) & lane_mask;
    assign rd_lane   = (x2a_rddt & lane_mask) << rd_shift;
    assign rd_merged = (rd_buf & ~(lane_mask << rd_shift)) | rd_lane;

    assign mode_chg = (sdr_width != width_q) &&
                      ((wr_xfr_count != 3'd0) || (rd_xfr_count != 3'd0));

    assign wr_base     = x2a_wrstart ? 3'd0 : wr_xfr_count;
    assign wr_at_end   = (wr_base == last_idx);
    assign app_wr_next = x2a_wrnext && wr_at_end;
    assign rd_at_end   = (rd_xfr_count == last_idx);

    always_comb begin
        wr_cnt_nxt = wr_xfr_count;
        wr_err_set = 1'b0;
        if (mode_chg) begin
            wr_cnt_nxt = 3'd0;
        end else if (x2a_wrnext) begin
            wr_cnt_nxt = (wr_at_end || x2a_wrlast) ? 3'd0 : wr_base + 3'd1;
            wr_err_set = x2a_wrlast && !wr_at_end;
        end else if (x2a_wrstart || x2a_wrlast) begin
            wr_cnt_nxt = 3'd0;
            wr_err_set = x2a_wrlast && (wr_xfr_count != 3'd0);
        end
    end

    // A read burst ending short leaves its partial lanes in rd_buf; they are simply overwritten later.
    always_comb begin
        rd_cnt_nxt = rd_xfr_count;
        rd_err_set = 1'b0;
        rd_load    = 1'b0;
        rd_done    = 1'b0;
        if (mode_chg) begin
            rd_cnt_nxt = 3'd0;
        end else if (x2a_rdok) begin
            rd_load = 1'b1;
            if (rd_at_end) begin
                rd_done    = 1'b1;
                rd_cnt_nxt = 3'd0;
            end else if (x2a_rdlast) begin
                rd_err_set = 1'b1;
                rd_cnt_nxt = 3'd0;
            end else begin
                rd_cnt_nxt = rd_xfr_count + 3'd1;
            end
        end else if (x2a_rdlast) begin
            rd_cnt_nxt = 3'd0;
            rd_err_set = (rd_xfr_count != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            width_q        <= 2'b00;
            wr_xfr_count   <= 3'd0;
            rd_xfr_count   <= 3'd0;
            rd_buf         <= '0;
            app_rd_data    <= '0;
            app_rd_valid   <= 1'b0;
            wr_partial_err <= 1'b0;
            rd_partial_err <= 1'b0;
            mode_err       <= 1'b0;
        end else begin
            width_q      <= sdr_width;
            wr_xfr_count <= wr_cnt_nxt;
            rd_xfr_count <= rd_cnt_nxt;
            app_rd_valid <= rd_done;
            if (rd_load) begin
                rd_buf <= rd_merged;
            end
            if (rd_done) begin
                app_rd_data <= rd_merged;
            end
            // A set event takes priority over a coincident clear.
            wr_partial_err <= wr_err_set | (wr_partial_err & ~err_clr);
            rd_partial_err <= rd_err_set | (rd_partial_err & ~err_clr);
            mode_err       <= mode_chg   | (mode_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_sdr_width_conv_engine.sv
// Directed bench for sdr_width_conv_engine: a 32-bit and a 64-bit instance share clock and reset.
module tb_sdr_width_conv_engine;

    logic clk = 1'b0;
    logic reset_n;

    logic [1:0]  width;
    logic [31:0] wr_data;
    logic        wrstart, wrnext, wrlast, rdok, rdlast, err_clr;
    logic [31:0] rddt;
    logic        wr_next, rd_valid, wr_perr, rd_perr, merr;
    logic [31:0] wrdt, rd_data;
    logic [2:0]  wr_cnt, rd_cnt;

    logic [1:0]  width_w;
    logic [63:0] wr_data_w;
    logic        wrstart_w, wrnext_w, wrlast_w, rdok_w, rdlast_w, err_clr_w;
    logic [63:0] rddt_w;
    logic        wr_next_w, rd_valid_w, wr_perr_w, rd_perr_w, merr_w;
    logic [63:0] wrdt_w, rd_data_w;
    logic [2:0]  wr_cnt_w, rd_cnt_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdr_width_conv_engine #(.APP_DW(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .sdr_width(width),
        .app_wr_data(wr_data), .app_wr_next(wr_next),
        .x2a_wrstart(wrstart), .x2a_wrnext(wrnext), .x2a_wrlast(wrlast),
        .a2x_wrdt(wrdt), .x2a_rdok(rdok), .x2a_rdlast(rdlast), .x2a_rddt(rddt),
        .app_rd_data(rd_data), .app_rd_valid(rd_valid),
        .wr_xfr_count(wr_cnt), .rd_xfr_count(rd_cnt),
        .wr_partial_err(wr_perr), .rd_partial_err(rd_perr), .mode_err(merr),
        .err_clr(err_clr)
    );

    sdr_width_conv_engine #(.APP_DW(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .sdr_width(width_w),
        .app_wr_data(wr_data_w), .app_wr_next(wr_next_w),
        .x2a_wrstart(wrstart_w), .x2a_wrnext(wrnext_w), .x2a_wrlast(wrlast_w),
        .a2x_wrdt(wrdt_w), .x2a_rdok(rdok_w), .x2a_rdlast(rdlast_w), .x2a_rddt(rddt_w),
        .app_rd_data(rd_data_w), .app_rd_valid(rd_valid_w),
        .wr_xfr_count(wr_cnt_w), .rd_xfr_count(rd_cnt_w),
        .wr_partial_err(wr_perr_w), .rd_partial_err(rd_perr_w), .mode_err(merr_w),
        .err_clr(err_clr_w)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wrstart = 0; wrnext = 0; wrlast = 0; rdok = 0; rdlast = 0; err_clr = 0;
        rddt = '0;
        wrstart_w = 0; wrnext_w = 0; wrlast_w = 0; rdok_w = 0; rdlast_w = 0; err_clr_w = 0;
        rddt_w = '0;
    endtask

    task automatic test_reset;
        reset_n = 0; width = 2'b00; wr_data = '0; width_w = 2'b00; wr_data_w = '0;
        idle();
        tick(); tick();
        n_vec++; if (wr_cnt !== 3'd0 || rd_cnt !== 3'd0) begin n_err++;
            $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", wr_cnt, rd_cnt); end
        n_vec++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin n_err++;
            $display("[TB] FAIL reset_rd: got %h/%b want 0/0", rd_data, rd_valid); end
        n_vec++; if ({wr_perr, rd_perr, merr} !== 3'b000) begin n_err++;
            $display("[TB] FAIL reset_errs: got %b want 000", {wr_perr, rd_perr, merr}); end
        n_vec++; if (rd_data_w !== 64'h0 || rd_valid_w !== 1'b0) begin n_err++;
            $display("[TB] FAIL reset_rd64: got %h/%b want 0/0", rd_data_w, rd_valid_w); end
        reset_n = 1;
    endtask

    task automatic test_half_write;
        width = 2'b01; idle(); tick();
        wr_data = 32'hA5A5_1234; wrstart = 1; wrnext = 1;
        #2;
        n_vec++; if (wrdt !== 32'h0000_1234 || wr_next !== 1'b0) begin n_err++;
            $display("[TB] FAIL half_wr_beat0: got %h/%b want 00001234/0", wrdt, wr_next); end
        tick();
        n_vec++; if (wr_cnt !== 3'd1) begin n_err++;
            $display("[TB] FAIL half_wr_cnt0: got %0d want 1", wr_cnt); end
        wrstart = 0; wrnext = 1; wrlast = 1;
        #2;
        n_vec++; if (wrdt !== 32'h0000_A5A5 || wr_next !== 1'b1) begin n_err++;
            $display("[TB] FAIL half_wr_beat1: got %h/%b want 0000a5a5/1", wrdt, wr_next); end
        tick();
        n_vec++; if (wr_cnt !== 3'd0 || wr_perr !== 1'b0) begin n_err++;
            $display("[TB] FAIL half_wr_end: got cnt %0d err %b want 0/0", wr_cnt, wr_perr); end
        idle();
    endtask

    task automatic test_quarter_read;
        logic [7:0] qb [4];
        qb = '{8'h11, 8'h22, 8'h33, 8'h44};
        width = 2'b10; idle(); tick();
        for (int i = 0; i < 4; i++) begin
            rdok = 1; rddt = {24'hFFFFFF, qb[i]}; rdlast = (i == 3);
            tick();
            if (i < 3) begin
                n_vec++; if (rd_valid !== 1'b0 || rd_cnt !== 3'(i + 1)) begin n_err++;
                    $display("[TB] FAIL q_rd_beat%0d: got valid %b cnt %0d want 0/%0d",
                             i, rd_valid, rd_cnt, i + 1); end
            end
        end
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h4433_2211) begin n_err++;
            $display("[TB] FAIL q_rd_word: got %h/%b want 44332211/1", rd_data, rd_valid); end
        n_vec++; if (rd_cnt !== 3'd0 || rd_perr !== 1'b0) begin n_err++;
            $display("[TB] FAIL q_rd_end: got cnt %0d err %b want 0/0", rd_cnt, rd_perr); end
        idle(); tick();
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 32'h4433_2211) begin n_err++;
            $display("[TB] FAIL q_rd_hold: got %h/%b want 44332211/0", rd_data, rd_valid); end
    endtask

    task automatic test_full_read;
        width = 2'b00; idle(); tick();
        for (int k = 1; k <= 5; k++) begin
            rdok = 1; rddt = 32'(k);
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'(k) || rd_cnt !== 3'd0) begin n_err++;
                $display("[TB] FAIL full_rd_%0d: got %h/%b cnt %0d want %0d/1/0",
                         k, rd_data, rd_valid, rd_cnt, k); end
        end
        idle(); tick();
        n_vec++; if (rd_valid !== 1'b0 || merr !== 1'b0) begin n_err++;
            $display("[TB] FAIL full_rd_stop: got valid %b merr %b want 0/0", rd_valid, merr); end
    endtask

    task automatic test_partial_write;
        width = 2'b10; idle(); tick();
        wr_data = 32'hDEAD_BEEF; wrstart = 1; wrnext = 1;
        #2;
        n_vec++; if (wrdt !== 32'h0000_00EF) begin n_err++;
            $display("[TB] FAIL pw_lane0: got %h want 000000ef", wrdt); end
        tick();
        wrstart = 0; wrnext = 1; wrlast = 1;
        #2;
        n_vec++; if (wrdt !== 32'h0000_00BE || wr_next !== 1'b0) begin n_err++;
            $display("[TB] FAIL pw_lane1: got %h/%b want 000000be/0", wrdt, wr_next); end
        tick();
        n_vec++; if (wr_perr !== 1'b1 || wr_cnt !== 3'd0) begin n_err++;
            $display("[TB] FAIL pw_err: got err %b cnt %0d want 1/0", wr_perr, wr_cnt); end
        idle(); err_clr = 1; tick();
        n_vec++; if (wr_perr !== 1'b0) begin n_err++;
            $display("[TB] FAIL pw_clr: got %b want 0", wr_perr); end
        wrstart = 1; wrnext = 1; wrlast = 1; err_clr = 1;
        tick();
        n_vec++; if (wr_perr !== 1'b1) begin n_err++;
            $display("[TB] FAIL pw_set_wins: got %b want 1", wr_perr); end
        idle(); err_clr = 1; tick();
        idle();
    endtask

    task automatic test_mode_change;
        logic [7:0] mb [4];
        mb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        width = 2'b01; idle(); tick();
        rdok = 1; rddt = 32'h0000_BEEF; tick();
        n_vec++; if (rd_cnt !== 3'd1) begin n_err++;
            $display("[TB] FAIL mc_cnt1: got %0d want 1", rd_cnt); end
        width = 2'b10; rdok = 1; rddt = 32'h1234_5678; tick();
        n_vec++; if (merr !== 1'b1 || rd_cnt !== 3'd0 || rd_valid !== 1'b0) begin n_err++;
            $display("[TB] FAIL mc_detect: got merr %b cnt %0d valid %b want 1/0/0",
                     merr, rd_cnt, rd_valid); end
        for (int i = 0; i < 4; i++) begin
            rdok = 1; rddt = {24'h5A5A5A, mb[i]}; tick();
        end
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'hDDCC_BBAA || merr !== 1'b1) begin n_err++;
            $display("[TB] FAIL mc_reassemble: got %h/%b merr %b want ddccbbaa/1/1",
                     rd_data, rd_valid, merr); end
        idle(); err_clr = 1; tick();
        idle();
    endtask

    task automatic test_eighth_64;
        width_w = 2'b11; idle(); tick();
        for (int i = 0; i < 8; i++) begin
            rdok_w = 1; rddt_w = {56'hC3C3C3_C3C3C3C3, 8'(i + 1)}; tick();
        end
        n_vec++; if (rd_valid_w !== 1'b1 || rd_data_w !== 64'h0807_0605_0403_0201 || merr_w !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL e64_word: got %h/%b merr %b want 0807060504030201/1/0",
                     rd_data_w, rd_valid_w, merr_w); end
        for (int i = 0; i < 3; i++) begin
            rdok_w = 1; rddt_w = {56'h0, 8'(8'h90 + i)}; tick();
        end
        n_vec++; if (rd_cnt_w !== 3'd3) begin n_err++;
            $display("[TB] FAIL e64_cnt3: got %0d want 3", rd_cnt_w); end
        idle(); reset_n = 0; tick(); reset_n = 1;
        n_vec++; if (rd_cnt_w !== 3'd0 || rd_data_w !== 64'h0 || rd_valid_w !== 1'b0 || merr_w !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL e64_reset: got cnt %0d data %h valid %b merr %b want 0/0/0/0",
                     rd_cnt_w, rd_data_w, rd_valid_w, merr_w); end
        for (int i = 0; i < 8; i++) begin
            rdok_w = 1; rddt_w = {56'hFFFF_FFFF_FFFF_FF, 8'(8'h21 + i)}; tick();
            if (i < 7) begin
                n_vec++; if (rd_valid_w !== 1'b0) begin n_err++;
                    $display("[TB] FAIL e64_early_valid%0d: got %b want 0", i, rd_valid_w); end
            end
        end
        n_vec++; if (rd_valid_w !== 1'b1 || rd_data_w !== 64'h2827_2625_2423_2221 || merr_w !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL e64_fresh: got %h/%b merr %b want 2827262524232221/1/0",
                     rd_data_w, rd_valid_w, merr_w); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_half_write();
        test_quarter_read();
        test_full_read();
        test_partial_write();
        test_mode_change();
        test_eighth_64();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
